// File: rtl/glyph_pkg.sv
`default_nettype none
// glyph_pkg: glyph geometry defaults shared with the overlay text buffer, plus sizing helpers.
package glyph_pkg;

  localparam int GLYPH_W_DEF = 8;
  localparam int GLYPH_H_DEF = 8;

  function automatic int glyph_bits(input int w, input int h);
    return w * h;
  endfunction

  function automatic int glyph_idx_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  function automatic int axis_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/glyph_axis_counter.sv
`default_nettype none
// glyph_axis_counter: scaled wrap counter for one glyph axis (rev 1.0).
// idx/sub are the coordinate of the current pixel; the registered copy holds the previous one.
module glyph_axis_counter
  import glyph_pkg::*;
#(
  parameter int LEN     = 8,
  parameter int SCALE_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    advance,
  input  logic [SCALE_W-1:0]      scale,
  output logic [axis_w(LEN)-1:0]  idx,
  output logic [SCALE_W-1:0]      sub
);

  localparam int IW = axis_w(LEN);

  logic [IW-1:0]      idx_q;
  logic [SCALE_W-1:0] sub_q;

  always_comb begin
    idx = idx_q;
    sub = sub_q;
    if (clear) begin
      idx = '0;
      sub = '0;
    end else if (advance) begin
      if (sub_q < scale) begin
        sub = sub_q + 1'b1;
      end else begin
        sub = '0;
        idx = (idx_q == IW'(LEN - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      sub_q <= '0;
    end else begin
      idx_q <= idx;
      sub_q <= sub;
    end
  end

endmodule
`default_nettype wire

// File: rtl/glyph_raster.sv
`default_nettype none
// glyph_raster: scaled, tiled glyph bitmap onto a pixel stream, 2-cycle dot latency (rev 1.0).
// Define GLYPH_DBUF_EN for a shadow glyph register that swaps in on sof (tear-free updates).
module glyph_raster
  import glyph_pkg::*;
#(
  parameter int GLYPH_W = GLYPH_W_DEF,
  parameter int GLYPH_H = GLYPH_H_DEF,
  parameter int SCALE_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         glyph_load,
  input  logic [GLYPH_W*GLYPH_H-1:0]   glyph_data,
  input  logic [SCALE_W-1:0]           scale,
  input  logic                         px_valid,
  input  logic                         px_sol,
  input  logic                         px_sof,
  output logic                         dot_valid,
  output logic                         dot
);

  localparam int NBITS = glyph_bits(GLYPH_W, GLYPH_H);
  localparam int IDX_W = glyph_idx_w(GLYPH_W, GLYPH_H);
  localparam int HW    = axis_w(GLYPH_W);
  localparam int VW    = axis_w(GLYPH_H);

  logic                 pix_sof;
  logic                 h_clear;
  logic                 h_adv;
  logic                 v_adv;
  logic [SCALE_W-1:0]   scale_q;
  logic [HW-1:0]        h_idx;
  logic [VW-1:0]        v_idx;
  logic [SCALE_W-1:0]   h_sub;
  logic [SCALE_W-1:0]   v_sub;
  logic                 unused_sub;
  logic [IDX_W-1:0]     index;
  logic [NBITS-1:0]     active;
  logic [IDX_W-1:0]     s1_idx;
  logic                 s1_valid;

  assign pix_sof = px_valid & px_sof;
  assign h_clear = px_valid & (px_sol | px_sof);
  assign h_adv   = px_valid & ~px_sol & ~px_sof;
  assign v_adv   = px_valid & px_sol & ~px_sof;

  // Sub-steps only pace the counters; the lookup needs just the glyph coordinate.
  assign unused_sub = ^{h_sub, v_sub};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q <= '0;
    end else if (pix_sof) begin
      scale_q <= scale;
    end
  end

  glyph_axis_counter #(
    .LEN     (GLYPH_W),
    .SCALE_W (SCALE_W)
  ) u_h_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (h_clear),
    .advance (h_adv),
    .scale   (scale_q),
    .idx     (h_idx),
    .sub     (h_sub)
  );

  glyph_axis_counter #(
    .LEN     (GLYPH_H),
    .SCALE_W (SCALE_W)
  ) u_v_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pix_sof),
    .advance (v_adv),
    .scale   (scale_q),
    .idx     (v_idx),
    .sub     (v_sub)
  );

  // Row 0 col 0 sits at the MSB of the row-major bitmap.
  always_comb begin
    index = IDX_W'(NBITS - 1 - (int'(v_idx) * GLYPH_W + int'(h_idx)));
  end

`ifdef GLYPH_DBUF_EN
  logic [NBITS-1:0] shadow;

  // A load coincident with sof bypasses the shadow so that frame starts with the new glyph.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (glyph_load) begin
        shadow <= glyph_data;
      end
      if (pix_sof) begin
        active <= glyph_load ? glyph_data : shadow;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (glyph_load) begin
      active <= glyph_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_idx    <= '0;
      s1_valid  <= 1'b0;
      dot       <= 1'b0;
      dot_valid <= 1'b0;
    end else begin
      s1_idx    <= index;
      s1_valid  <= px_valid;
      dot       <= s1_valid & active[s1_idx];
      dot_valid <= s1_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_glyph_raster.sv
`default_nettype none
// tb_glyph_raster: scoreboard bench for glyph_raster (geometric model, 2-cycle latency check).
module tb_glyph_raster;

  localparam int GW = 8;
  localparam int GH = 8;
  localparam int SW = 2;
  localparam int NB = GW * GH;

  localparam logic [NB-1:0] G_TOP   = 64'h8000_0000_0000_0000;
  localparam logic [NB-1:0] G_BOT   = 64'h0000_0000_0000_0001;
  localparam logic [NB-1:0] G_CORN  = 64'h8000_0000_0000_0001;
  localparam logic [NB-1:0] G_MIXED = 64'hF0E1_D2C3_B4A5_9687;

  typedef struct {
    bit d;
    int c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          glyph_load = 1'b0;
  logic [NB-1:0] glyph_data = '0;
  logic [SW-1:0] scale = '0;
  logic          px_valid = 1'b0;
  logic          px_sol = 1'b0;
  logic          px_sof = 1'b0;
  logic          dot_valid;
  logic          dot;

  exp_t          sbq[$];
  exp_t          mon_e;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            ones = 0;

  int            m_x = 0;
  int            m_y = 0;
  int            m_scale = 0;
  logic [NB-1:0] m_act = '0;
  logic [NB-1:0] m_shd = '0;

  glyph_raster #(
    .GLYPH_W (GW),
    .GLYPH_H (GH),
    .SCALE_W (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .glyph_load (glyph_load),
    .glyph_data (glyph_data),
    .scale      (scale),
    .px_valid   (px_valid),
    .px_sol     (px_sol),
    .px_sof     (px_sof),
    .dot_valid  (dot_valid),
    .dot        (dot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dot_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL stray_dot: dot_valid=1 dot=%0b at cycle %0d, required no output", dot, cyc);
        end else begin
          mon_e = sbq.pop_front();
          if (dot !== mon_e.d || cyc != mon_e.c + 2) begin
            errors++;
            $display("FAIL dot: got dot=%0b at cycle %0d, required dot=%0b at cycle %0d",
                     dot, cyc, mon_e.d, mon_e.c + 2);
          end
          if (dot === 1'b1) ones++;
        end
      end else begin
        if (sbq.size() != 0 && sbq[0].c + 2 <= cyc) begin
          checks++;
          errors++;
          mon_e = sbq.pop_front();
          $display("FAIL missing_dot: dot_valid=0 at cycle %0d, required 1 (pixel of cycle %0d)", cyc, mon_e.c);
        end
        if (dot !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL idle_dot: dot=%0b while dot_valid=0, required 0", dot);
        end
      end
    end
  end

  // One pixel slot. The expected dot comes from the raw pixel position divided by the magnification.
  task automatic drive(input bit v, input bit sol, input bit sof, input bit ld,
                       input logic [NB-1:0] data, input int sc);
    exp_t e;
    int   h;
    int   vv;
    px_valid   = v;
    px_sol     = sol;
    px_sof     = sof;
    glyph_load = ld;
    glyph_data = data;
    scale      = SW'(sc);
`ifdef GLYPH_DBUF_EN
    if (v && sof) m_act = ld ? data : m_shd;
    if (ld) m_shd = data;
`else
    if (ld) m_act = data;
`endif
    if (v) begin
      if (sof) begin
        m_x = 0;
        m_y = 0;
        m_scale = sc;
      end else if (sol) begin
        m_x = 0;
        m_y++;
      end else begin
        m_x++;
      end
      h  = (m_x / (m_scale + 1)) % GW;
      vv = (m_y / (m_scale + 1)) % GH;
      e.d = m_act[NB - 1 - (vv * GW + h)];
      e.c = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    px_valid   = 1'b0;
    px_sol     = 1'b0;
    px_sof     = 1'b0;
    glyph_load = 1'b0;
  endtask

  task automatic frame(input int lines, input int pxs, input int sc,
                       input int ld_l, input int ld_p, input logic [NB-1:0] ld_d);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < pxs; p++) begin
        drive(1'b1, p == 0, (l == 0) && (p == 0), (l == ld_l) && (p == ld_p), ld_d, sc);
      end
    end
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d dots outstanding, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_ones(input string name, input int req);
    checks++;
    if (ones != req) begin
      errors++;
      $display("FAIL %s_ones: counted %0d set dots, required %0d", name, ones, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (dot_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dot_valid: got %0b, required 0", dot_valid);
    end
    checks++;
    if (dot !== 1'b0) begin
      errors++;
      $display("FAIL reset_dot: got %0b, required 0", dot);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_dot();
    drive(1'b0, 1'b0, 1'b0, 1'b1, G_TOP, 0);
    ones = 0;
    frame(8, 8, 0, -1, -1, '0);
    drain("single");
    check_ones("single", 1);
  endtask

  task automatic test_scale();
    ones = 0;
    frame(16, 16, 1, -1, -1, '0);
    drain("scale");
    check_ones("scale", 4);
  endtask

  task automatic test_tiling();
    drive(1'b0, 1'b0, 1'b0, 1'b1, G_CORN, 0);
    ones = 0;
    frame(9, 16, 0, -1, -1, '0);
    drain("tiling");
    check_ones("tiling", 6);
  endtask

  // Invalid slots carry sol/sof and a changed scale; none of it may move the coordinates.
  task automatic test_gaps();
    drive(1'b0, 1'b0, 1'b0, 1'b1, G_MIXED, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
    for (int i = 0; i < 48; i++) begin
      drive(1'b0, 1'b1, (i % 3) == 0, 1'b0, '0, 3);
      drive(1'b1, (i % 8) == 7, 1'b0, 1'b0, '0, 3);
    end
    drain("gaps");
  endtask

  task automatic test_load();
    drive(1'b0, 1'b0, 1'b0, 1'b1, G_TOP, 0);
    ones = 0;
    frame(9, 8, 0, 3, 2, G_BOT);
    drain("load_mid");
    check_ones("load_mid", 2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, G_TOP, 0);
    ones = 0;
    frame(8, 8, 0, 0, 0, G_BOT);
    drain("load_sof");
    check_ones("load_sof", 1);
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 1'b0, 1'b1, G_MIXED, 0);
    frame(3, 12, 2, -1, -1, '0);
    frame(4, 9, 0, -1, -1, '0);
    frame(2, 20, 3, -1, -1, '0);
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b0, 1'b1, G_TOP, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dot_valid !== 1'b0 || dot !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: dot_valid=%0b dot=%0b, required 0 0", dot_valid, dot);
    end
    sbq.delete();
    m_act = '0;
    m_shd = '0;
    @(posedge clk);
    #1;
    checks++;
    if (dot_valid !== 1'b0 || dot !== 1'b0) begin
      errors++;
      $display("FAIL midreset_edge: dot_valid=%0b dot=%0b, required 0 0", dot_valid, dot);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, G_TOP, 0);
    ones = 0;
    frame(8, 8, 0, -1, -1, '0);
    drain("midreset");
    check_ones("midreset", 1);
  endtask

  initial begin
    test_reset();
    test_single_dot();
    test_scale();
    test_tiling();
    test_gaps();
    test_load();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glyph_raster.md
Name: glyph_raster

Overview:
- Parametrised successor to the fixed 8x8 character dot lookup.
- Renders a GLYPH_W x GLYPH_H bitmap onto a raster pixel stream.
- Tracks in-glyph coordinates internally from stream markers, with an integer scale factor on both axes and horizontal/vertical tiling.
- Sits between the video timing / overlay position logic and the pixel mixer; emits one dot per valid pixel.

Parameters:
- GLYPH_W, 8, glyph width in dots (>=2)
- GLYPH_H, 8, glyph height in dots (>=2)
- SCALE_W, 2, width of scale input; magnification = scale+1 (1..2^SCALE_W)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- glyph_load  in  1  strobe: capture glyph_data this cycle
- glyph_data  in  GLYPH_W*GLYPH_H  bitmap; MSB = row 0 col 0, row-major
- scale  in  SCALE_W  magnification minus one; sampled at sof
- px_valid  in  1  pixel present this cycle
- px_sol  in  1  first pixel of a line (qualified by px_valid)
- px_sof  in  1  first pixel of a frame/box (qualified by px_valid; implies sol)
- dot_valid  out  1  dot output valid
- dot  out  1  glyph dot for the pixel issued 2 cycles earlier

Behaviour:
- Reset (async, rst_n=0) clears:
  - h_idx, h_sub, v_idx, v_sub, scale_q, active glyph, shadow glyph, pipeline
  - dot=0, dot_valid=0
- Reset mid-stream flushes the pipeline: dot_valid=0 immediately; no stale dot appears after release.
- Counters advance only on px_valid=1. Coordinate used for the current valid pixel:
  - sof: h=0, hsub=0, v=0, vsub=0; scale_q<=scale in the same cycle, and the new value applies to this pixel.
  - sol (no sof): h=0, hsub=0; vertical advances. If vsub<scale_q then vsub+1, else vsub=0 and v=(v==GLYPH_H-1)?0:v+1.
  - Otherwise: horizontal advances from the previous pixel, same rule with h/hsub/GLYPH_W.
- Wrap-around tiles the glyph in both axes; there is no saturation.
- sol/sof with px_valid=0 are ignored.
- Bit index = GLYPH_W*GLYPH_H-1 - (v*GLYPH_W + h); index width = clog2(GLYPH_W*GLYPH_H).
- Pipeline, latency exactly 2 cycles, fixed; no backpressure:
  - Stage 1 registers the index and valid.
  - Stage 2 registers dot = active[index] and dot_valid.
- While dot_valid=0, dot holds 0.
- A scale change outside sof has no effect until the next sof.

Optional Feature:
- GLYPH_DBUF_EN defined:
  - glyph_load writes the shadow register.
  - Shadow copies to active on a valid sof pixel, before that pixel's lookup, giving tear-free updates.
  - glyph_load coincident with a valid sof bypasses the shadow: active takes glyph_data directly and that sof pixel uses the new glyph.
- GLYPH_DBUF_EN undefined:
  - No shadow register.
  - glyph_load writes active directly.
  - Pixels whose stage-2 lookup occurs in or after the load cycle+1 use the new glyph.

Decomposition:
- Package glyph_pkg:
  - localparam functions for glyph bit count and index width (clog2)
  - default GLYPH_W/GLYPH_H constants shared with the overlay text buffer
- One sub-module glyph_axis_counter (params LEN, SCALE_W):
  - scaled wrap counter with clear and advance inputs, outputs idx/sub
  - instantiated twice (horizontal, vertical)

Test Plan:
- Glyph 0x8000_0000_0000_0000, scale=0, sof then 7 px, 8 lines of 8 px -> dot=1 only on line 0 px 0, dot_valid 2 cycles after each px_valid.
- Same glyph, scale=1 -> dot=1 at (x,y) in {0,1}x{0,1}; 0 elsewhere within 16x16.
- Glyph 0x8000_0000_0000_0001, line of 16 px, scale=0 -> dot=1 at x=0, 8 on line 0; dot=1 at x=7, 15 on line 7; line 8 repeats line 0.
- DBUF_EN: active 0x80.., load 0x00..01 mid-frame -> no change until next sof; load+sof same cycle -> that pixel uses 0x00..01 (dot=0), bit 0 at (7,7) is set.
- Gaps: px_valid toggling 1,0,1 with sol asserted while invalid -> counters unchanged by invalid cycles.
- Assert rst_n=0 mid-line for 1 cycle -> dot_valid=0, dot=0 next edge; after release with sof, output matches the first scenario.
